// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks: the FSM state encoding
// and the helper that sizes the bit counter.
package serial_arith_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        RUN  = ST_RUN,
        DONE = ST_DONE
    } state_t;

    // Bits needed to count 0..n-1; never less than one bit.
    function automatic int clog2(input int n);
        int w;
        int v;
        w = 0;
        v = n - 1;
        while (v > 0) begin
            w = w + 1;
            v = v >> 1;
        end
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/fullsub.sv
// Combinational one-bit full subtractor: d = x - y - bin, with borrow out.
module fullsub (
    input  logic i_x,
    input  logic i_y,
    input  logic i_bin,
    output logic o_d,
    output logic o_bout
);

    assign o_d    = i_x ^ i_y ^ i_bin;
    assign o_bout = (~i_x & i_y) | (~i_x & i_bin) | (i_y & i_bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial N-bit subtractor, D = X - Y - borrowin, one bit per clock, LSB first.
// Define SERIAL_SUB_OVF_EN to add the o_ovf signed-overflow output.
module serial_subtractor
    import serial_arith_pkg::*;
#(
    parameter int N = 32
) (
    input  logic         Clock,
    input  logic         Resetn,
    input  logic         i_start,
    input  logic         i_borrowin,
    input  logic [N-1:0] i_x,
    input  logic [N-1:0] i_y,
    output logic [N-1:0] o_d,
    output logic         o_borrowout,
    output logic         o_busy,
    output logic         o_done
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic         o_ovf
`endif
);

    localparam int             KW     = clog2(N);
    localparam logic [KW-1:0]  K_LAST = KW'(N - 1);

    state_t          r_state;
    logic [N-1:0]    r_xs;
    logic [N-1:0]    r_ys;
    logic [N-2:0]    r_rs;
    logic            r_b;
    logic [KW-1:0]   r_k;
    logic [N-1:0]    r_d;
    logic            r_bout;
    logic            r_busy;
    logic            r_done;
`ifdef SERIAL_SUB_OVF_EN
    logic            r_ovf;
`endif

    logic            w_d;
    logic            w_bout;
    logic [N-1:0]    w_rs_next;

    fullsub u_fullsub (
        .i_x    (r_xs[0]),
        .i_y    (r_ys[0]),
        .i_bin  (r_b),
        .o_d    (w_d),
        .o_bout (w_bout)
    );

    // The result register keeps only the upper N-1 bits; the newest bit is w_d.
    assign w_rs_next = {w_d, r_rs};

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_state <= IDLE;
            r_xs    <= '0;
            r_ys    <= '0;
            r_rs    <= '0;
            r_b     <= 1'b0;
            r_k     <= '0;
            r_d     <= '0;
            r_bout  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            r_ovf   <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    r_done <= 1'b0;
                    if (i_start) begin
                        r_xs    <= i_x;
                        r_ys    <= i_y;
                        r_b     <= i_borrowin;
                        r_k     <= '0;
                        r_busy  <= 1'b1;
                        r_state <= RUN;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                RUN: begin
                    r_xs <= r_xs >> 1;
                    r_ys <= r_ys >> 1;
                    r_rs <= w_rs_next[N-1:1];
                    r_b  <= w_bout;
                    r_k  <= r_k + 1'b1;
                    if (r_k == K_LAST) begin
                        r_d     <= w_rs_next;
                        r_bout  <= w_bout;
`ifdef SERIAL_SUB_OVF_EN
                        // Borrow out of the MSB versus borrow into it.
                        r_ovf   <= w_bout ^ r_b;
`endif
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_d         = r_d;
    assign o_borrowout = r_bout;
    assign o_busy      = r_busy;
    assign o_done      = r_done;
`ifdef SERIAL_SUB_OVF_EN
    assign o_ovf       = r_ovf;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor at N=8 and N=32, randomized against an
// arithmetic reference model. Honours SERIAL_SUB_OVF_EN for the ovf output.
module tb_serial_subtractor;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        s8, bin8;
    logic [7:0]  x8, y8;
    logic [7:0]  d8;
    logic        bo8, busy8, done8;
    logic        s32, bin32;
    logic [31:0] x32, y32;
    logic [31:0] d32;
    logic        bo32, busy32, done32;
`ifdef SERIAL_SUB_OVF_EN
    logic        ovf8, ovf32;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    serial_subtractor #(.N(8)) dut8 (
        .Clock       (clk),
        .Resetn      (rst_n),
        .i_start     (s8),
        .i_borrowin  (bin8),
        .i_x         (x8),
        .i_y         (y8),
        .o_d         (d8),
        .o_borrowout (bo8),
        .o_busy      (busy8),
        .o_done      (done8)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .o_ovf       (ovf8)
`endif
    );

    serial_subtractor #(.N(32)) dut32 (
        .Clock       (clk),
        .Resetn      (rst_n),
        .i_start     (s32),
        .i_borrowin  (bin32),
        .i_x         (x32),
        .i_y         (y32),
        .o_d         (d32),
        .o_borrowout (bo32),
        .o_busy      (busy32),
        .o_done      (done32)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .o_ovf       (ovf32)
`endif
    );

    // Reference: plain integer arithmetic on n-bit unsigned operands.
    function automatic void ref_model(input int n, input longint x, input longint y, input bit bin,
                                      output longint d, output bit bo, output bit ov);
        longint diff, sx, sy, sd, full, half;
        full = longint'(1) << n;
        half = longint'(1) << (n - 1);
        diff = x - y - longint'(bin);
        bo   = (diff < 0);
        d    = diff & (full - 1);
        sx   = (x >= half) ? x - full : x;
        sy   = (y >= half) ? y - full : y;
        sd   = sx - sy - longint'(bin);
        ov   = (sd < -half) || (sd > half - 1);
    endfunction

    task automatic op8(input logic [7:0] x, input logic [7:0] y, input logic bin,
                       input int poke, input string tag);
        int         cnt;
        logic [7:0] d_hold;
        bit         moved;
        longint     ed;
        bit         eb, eo;
        ref_model(8, longint'(x), longint'(y), bin, ed, eb, eo);
        @(negedge clk);
        x8 = x; y8 = y; bin8 = bin; s8 = 1'b1;
        @(negedge clk);
        s8 = 1'b0; x8 = 8'($urandom); y8 = 8'($urandom); bin8 = 1'($urandom);
        d_hold = d8;
        moved  = 1'b0;
        total++;
        if (busy8 !== 1'b1 || done8 !== 1'b0) begin
            bad++;
            $display("FAIL %s accept: busy=%b done=%b, required busy=1 done=0", tag, busy8, done8);
        end
        cnt = 0;
        while (done8 !== 1'b1 && cnt < 40) begin
            @(negedge clk);
            cnt++;
            if (cnt == poke) begin
                s8 = 1'b1; x8 = 8'hAA; y8 = 8'h0F;
            end else begin
                s8 = 1'b0;
            end
            if (done8 !== 1'b1 && (d8 !== d_hold || busy8 !== 1'b1)) moved = 1'b1;
        end
        s8 = 1'b0;
        total++;
        if (cnt != 8) begin
            bad++;
            $display("FAIL %s latency: got %0d cycles, required 8", tag, cnt);
        end
        total++;
        if (moved) begin
            bad++;
            $display("FAIL %s run_hold: D or busy changed during RUN, required stable", tag);
        end
        total++;
        if (d8 !== 8'(ed) || bo8 !== eb || busy8 !== 1'b0) begin
            bad++;
            $display("FAIL %s result: D=%h bout=%b busy=%b, required D=%h bout=%b busy=0",
                     tag, d8, bo8, busy8, 8'(ed), eb);
        end
`ifdef SERIAL_SUB_OVF_EN
        total++;
        if (ovf8 !== eo) begin
            bad++;
            $display("FAIL %s ovf: got %b, required %b", tag, ovf8, eo);
        end
`endif
        @(negedge clk);
        total++;
        if (done8 !== 1'b0) begin
            bad++;
            $display("FAIL %s done_pulse: done=%b one cycle later, required 0", tag, done8);
        end
        $display("%s: X=%h Y=%h bin=%b -> D=%h bout=%b (%0d cycles)", tag, x, y, bin, d8, bo8, cnt);
    endtask

    task automatic op32(input logic [31:0] x, input logic [31:0] y, input logic bin, input string tag);
        int     cnt;
        longint ed;
        bit     eb, eo;
        ref_model(32, longint'(x), longint'(y), bin, ed, eb, eo);
        @(negedge clk);
        x32 = x; y32 = y; bin32 = bin; s32 = 1'b1;
        @(negedge clk);
        s32 = 1'b0; x32 = $urandom; y32 = $urandom;
        cnt = 0;
        while (done32 !== 1'b1 && cnt < 80) begin
            @(negedge clk);
            cnt++;
        end
        total++;
        if (cnt != 32) begin
            bad++;
            $display("FAIL %s latency: got %0d cycles, required 32", tag, cnt);
        end
        total++;
        if (d32 !== 32'(ed) || bo32 !== eb) begin
            bad++;
            $display("FAIL %s result: D=%h bout=%b, required D=%h bout=%b", tag, d32, bo32, 32'(ed), eb);
        end
`ifdef SERIAL_SUB_OVF_EN
        total++;
        if (ovf32 !== eo) begin
            bad++;
            $display("FAIL %s ovf: got %b, required %b", tag, ovf32, eo);
        end
`endif
        $display("%s: X=%h Y=%h bin=%b -> D=%h bout=%b", tag, x, y, bin, d32, bo32);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        s8 = 1'b0; bin8 = 1'b0; x8 = '0; y8 = '0;
        s32 = 1'b0; bin32 = 1'b0; x32 = '0; y32 = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (d8 !== 8'h00 || bo8 !== 1'b0 || busy8 !== 1'b0 || done8 !== 1'b0) begin
            bad++;
            $display("FAIL reset8: D=%h bout=%b busy=%b done=%b, required all 0", d8, bo8, busy8, done8);
        end
        total++;
        if (d32 !== 32'h0 || bo32 !== 1'b0 || busy32 !== 1'b0 || done32 !== 1'b0) begin
            bad++;
            $display("FAIL reset32: D=%h bout=%b busy=%b done=%b, required all 0", d32, bo32, busy32, done32);
        end
`ifdef SERIAL_SUB_OVF_EN
        total++;
        if (ovf8 !== 1'b0 || ovf32 !== 1'b0) begin
            bad++;
            $display("FAIL reset_ovf: ovf8=%b ovf32=%b, required 0", ovf8, ovf32);
        end
`endif
        $display("reset: outputs idle");
    endtask

    task automatic test_vectors();
        logic [7:0] xs [6] = '{8'h50, 8'h00, 8'h80, 8'h05, 8'hFF, 8'h7F};
        logic [7:0] ys [6] = '{8'h20, 8'h01, 8'h01, 8'h05, 8'hFF, 8'hFF};
        logic       bs [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 6; i++) op8(xs[i], ys[i], bs[i], 0, "vector");
    endtask

    task automatic test_ignore_start();
        op8(8'h3C, 8'h19, 1'b0, 3, "ignore_start");
    endtask

    task automatic test_back_to_back();
        int     cnt;
        longint ed;
        bit     eb, eo;
        @(negedge clk);
        x8 = 8'h50; y8 = 8'h20; bin8 = 1'b0; s8 = 1'b1;
        @(negedge clk);
        s8 = 1'b0;
        cnt = 0;
        while (done8 !== 1'b1 && cnt < 40) begin
            @(negedge clk);
            cnt++;
        end
        x8 = 8'h90; y8 = 8'h33; bin8 = 1'b0; s8 = 1'b1;
        @(negedge clk);
        s8 = 1'b0;
        total++;
        if (done8 !== 1'b0 || busy8 !== 1'b1 || d8 !== 8'h30) begin
            bad++;
            $display("FAIL b2b_accept: done=%b busy=%b D=%h, required done=0 busy=1 D=30", done8, busy8, d8);
        end
        cnt = 0;
        while (done8 !== 1'b1 && cnt < 40) begin
            @(negedge clk);
            cnt++;
        end
        ref_model(8, 64'h90, 64'h33, 1'b0, ed, eb, eo);
        total++;
        if (cnt != 8 || d8 !== 8'(ed) || bo8 !== eb) begin
            bad++;
            $display("FAIL b2b_result: cycles=%0d D=%h bout=%b, required cycles=8 D=%h bout=%b",
                     cnt, d8, bo8, 8'(ed), eb);
        end
`ifdef SERIAL_SUB_OVF_EN
        total++;
        if (ovf8 !== eo) begin
            bad++;
            $display("FAIL b2b_ovf: got %b, required %b", ovf8, eo);
        end
`endif
        $display("back_to_back: 50-20 then 90-33 -> D=%h (%0d cycles)", d8, cnt);
        @(negedge clk);
    endtask

    task automatic test_reset_mid_run();
        bit seen_done;
        @(negedge clk);
        x8 = 8'h77; y8 = 8'h11; bin8 = 1'b0; s8 = 1'b1;
        @(negedge clk);
        s8 = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++;
        if (d8 !== 8'h00 || bo8 !== 1'b0 || busy8 !== 1'b0 || done8 !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_run: D=%h bout=%b busy=%b done=%b, required all 0", d8, bo8, busy8, done8);
        end
`ifdef SERIAL_SUB_OVF_EN
        total++;
        if (ovf8 !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_run_ovf: got %b, required 0", ovf8);
        end
`endif
        @(negedge clk);
        rst_n = 1'b1;
        seen_done = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (done8 !== 1'b0 || busy8 !== 1'b0) seen_done = 1'b1;
        end
        total++;
        if (seen_done) begin
            bad++;
            $display("FAIL reset_abort: done or busy rose after abort, required idle");
        end
        $display("reset_mid_run: aborted");
        op8(8'hC4, 8'h4D, 1'b1, 0, "after_reset");
    endtask

    task automatic test_random();
        for (int i = 0; i < 1000; i++)
            op8(8'($urandom), 8'($urandom), 1'($urandom), 0, "rand8");
        for (int i = 0; i < 1000; i++)
            op32($urandom, $urandom, 1'($urandom), "rand32");
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid_run();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
